// File: rtl/shift_arb_pkg.sv
// Shared types for the shift arbiter slice.
//   shift_op_e  : shifter opcodes. 011 and 111 also decode as ROR/ROL.
//   arb_state_e : occupancy of the one-deep response register.
//   rsp_flags_t : status flags carried with each captured result.
//   wrap_inc    : index + 1 modulo n, used for the round-robin pointer.
package shift_arb_pkg;

  typedef enum logic [2:0] {
    OP_LSR = 3'b000,
    OP_ASR = 3'b001,
    OP_ROR = 3'b010,
    OP_LSL = 3'b100,
    OP_ASL = 3'b101,
    OP_ROL = 3'b110
  } shift_op_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic zf;
    logic vf;
  } rsp_flags_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/barrelshifter.sv
// Combinational barrel shifter with zero and overflow flags.
//   x_in  : operand
//   s_in  : shift amount, 0 .. D_SIZE-1
//   op_in : op[2] = left, op[1] = rotate, op[0] = arithmetic
//   y_out : result; zf_out : result is zero
//   vf_out: ASL only, a bit shifted out of the magnitude differs from the sign
module barrelshifter #(
  parameter int D_SIZE = 32
) (
  input  logic [D_SIZE-1:0]         x_in,
  input  logic [$clog2(D_SIZE)-1:0] s_in,
  input  logic [2:0]                op_in,
  output logic [D_SIZE-1:0]         y_out,
  output logic                      zf_out,
  output logic                      vf_out
);

  logic [D_SIZE-1:0] shl;
  logic [D_SIZE-1:0] rot_l;
  logic [D_SIZE-1:0] rot_r;

  always_comb begin
    shl   = x_in << s_in;
    // Rotates come out of a doubled copy of the operand.
    rot_r = D_SIZE'({x_in, x_in} >> s_in);
    rot_l = D_SIZE'(({x_in, x_in} << s_in) >> D_SIZE);
    y_out  = '0;
    vf_out = 1'b0;
    if (op_in[1]) begin
      y_out = op_in[2] ? rot_l : rot_r;
    end else if (!op_in[2]) begin
      y_out = op_in[0] ? $unsigned($signed(x_in) >>> s_in) : (x_in >> s_in);
    end else if (!op_in[0]) begin
      y_out = shl;
    end else begin
      // ASL keeps the sign bit; bits x[D-2 : D-1-s] leave the magnitude field.
      y_out = {x_in[D_SIZE-1], shl[D_SIZE-2:0]};
      for (int i = 0; i < D_SIZE - 1; i++) begin
        if ((i + int'(s_in) >= D_SIZE - 1) && (x_in[i] != x_in[D_SIZE-1])) begin
          vf_out = 1'b1;
        end
      end
    end
    zf_out = (y_out == '0);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_in,
// wrapping modulo N_REQ.
//   req_in    : request vector
//   ptr_in    : search start index
//   grant_out : one-hot grant (zero when nothing requests)
//   idx_out   : index of the granted request
//   any_out   : some request is present
module rr_arbiter
  import shift_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_in,
  input  logic [$clog2(N_REQ)-1:0] ptr_in,
  output logic [N_REQ-1:0]         grant_out,
  output logic [$clog2(N_REQ)-1:0] idx_out,
  output logic                     any_out
);

  localparam int IW = $clog2(N_REQ);

  int            cand_i;
  logic [IW-1:0] cand;

  always_comb begin
    grant_out = '0;
    idx_out   = '0;
    any_out   = 1'b0;
    cand_i    = 0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_i = int'(ptr_in) + k;
      if (cand_i >= N_REQ) cand_i = cand_i - N_REQ;
      cand = IW'(cand_i);
      if (!any_out && req_in[cand]) begin
        any_out         = 1'b1;
        grant_out[cand] = 1'b1;
        idx_out         = cand;
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrelshifter among N_REQ requesters,
// with a one-deep valid/ready result register.
//   clk_in, rst_in          : clock, synchronous active-high reset
//   req_valid_in/ready_out  : per-requester handshake (ready is one-hot or zero)
//   req_x_in/s_in/op_in     : packed per-requester payloads
//   rsp_valid_out/ready_in  : result handshake
//   rsp_id_out/y_out/zf_out/vf_out : captured result and owner
// Optional: SHIFT_ARB_PERF_EN adds xfer_cnt_out and stall_cnt_out counters.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int D_SIZE = 32,
  parameter int N_REQ  = 4
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [N_REQ-1:0]                 req_valid_in,
  output logic [N_REQ-1:0]                 req_ready_out,
  input  logic [N_REQ*D_SIZE-1:0]          req_x_in,
  input  logic [N_REQ*$clog2(D_SIZE)-1:0]  req_s_in,
  input  logic [N_REQ*3-1:0]               req_op_in,
  output logic                             rsp_valid_out,
  input  logic                             rsp_ready_in,
  output logic [$clog2(N_REQ)-1:0]         rsp_id_out,
  output logic [D_SIZE-1:0]                rsp_y_out,
  output logic                             rsp_zf_out,
`ifdef SHIFT_ARB_PERF_EN
  output logic [31:0]                      xfer_cnt_out,
  output logic [31:0]                      stall_cnt_out,
`endif
  output logic                             rsp_vf_out
);

  localparam int SW = $clog2(D_SIZE);
  localparam int IW = $clog2(N_REQ);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     rsp_id_q, rsp_id_d;
  logic [D_SIZE-1:0] rsp_y_q, rsp_y_d;
  rsp_flags_t        rsp_flags_q, rsp_flags_d;

  logic [N_REQ-1:0]  gnt_oh;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  logic              accept;
  logic              grant_fire;

  logic [D_SIZE-1:0] sh_x, sh_y;
  logic [SW-1:0]     sh_s;
  logic [2:0]        sh_op;
  logic              sh_zf, sh_vf;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_in    (req_valid_in),
    .ptr_in    (ptr_q),
    .grant_out (gnt_oh),
    .idx_out   (gnt_idx),
    .any_out   (gnt_any)
  );

  // Payload mux with constant slice indices.
  always_comb begin
    sh_x  = '0;
    sh_s  = '0;
    sh_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sh_x  = req_x_in[i*D_SIZE +: D_SIZE];
        sh_s  = req_s_in[i*SW +: SW];
        sh_op = req_op_in[i*3 +: 3];
      end
    end
  end

  barrelshifter #(.D_SIZE(D_SIZE)) u_shifter (
    .x_in   (sh_x),
    .s_in   (sh_s),
    .op_in  (sh_op),
    .y_out  (sh_y),
    .zf_out (sh_zf),
    .vf_out (sh_vf)
  );

  // A full register that is being drained can be refilled in the same cycle.
  assign accept        = !rst_in && ((state_q == EMPTY) || rsp_ready_in);
  assign grant_fire    = accept && gnt_any;
  assign req_ready_out = accept ? gnt_oh : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    if (grant_fire) begin
      state_d        = FULL;
      ptr_d          = IW'(wrap_inc(int'(gnt_idx), N_REQ));
      rsp_id_d       = gnt_idx;
      rsp_y_d        = sh_y;
      rsp_flags_d.zf = sh_zf;
      rsp_flags_d.vf = sh_vf;
    end else if ((state_q == FULL) && rsp_ready_in) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= EMPTY;
      ptr_q       <= '0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign rsp_valid_out = (state_q == FULL);
  assign rsp_id_out    = rsp_id_q;
  assign rsp_y_out     = rsp_y_q;
  assign rsp_zf_out    = rsp_flags_q.zf;
  assign rsp_vf_out    = rsp_flags_q.vf;

`ifdef SHIFT_ARB_PERF_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == FULL) begin
      if (rsp_ready_in) xfer_cnt_d  = xfer_cnt_q + 32'd1;
      else              stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign xfer_cnt_out  = xfer_cnt_q;
  assign stall_cnt_out = stall_cnt_q;
`endif

endmodule
